// File: rtl/hit_scorer_if.sv
// hit_scorer_if
// Bundles the scoring-stage signals that travel between the game logic and the
// hit scorer. The clock and reset are plain ports on the scorer, not part of
// this bundle.
//   score_enable    : high while the game is in the play state
//   note_strobe     : one-cycle tick; led_pattern is a new note this cycle
//   led_pattern[3:0]: pattern currently shown, bit i <-> key i
//   keys_n[3:0]     : raw active-low push buttons, asynchronous to clk
//   score_10s_digit : BCD tens digit of the score
//   score_1s_digit  : BCD ones digit of the score
//   streak[6:0]     : consecutive hits, saturating at 127
//   hit_pulse       : one-cycle pulse when a note is judged a hit
//   miss_pulse      : one-cycle pulse when a note is judged a miss
// master drives the game-side inputs; slave is the scorer.
interface hit_scorer_if;
    logic       score_enable;
    logic       note_strobe;
    logic [3:0] led_pattern;
    logic [3:0] keys_n;
    logic [3:0] score_10s_digit;
    logic [3:0] score_1s_digit;
    logic [6:0] streak;
    logic       hit_pulse;
    logic       miss_pulse;

    modport master (
        output score_enable, note_strobe, led_pattern, keys_n,
        input  score_10s_digit, score_1s_digit, streak, hit_pulse, miss_pulse
    );

    modport slave (
        input  score_enable, note_strobe, led_pattern, keys_n,
        output score_10s_digit, score_1s_digit, streak, hit_pulse, miss_pulse
    );
endinterface

// File: rtl/hit_scorer.sv
// hit_scorer
// Latches every LED pattern as a note, debounces the four KEY buttons and
// judges each note exactly once as a hit or a miss. Keeps a saturating
// two-digit BCD score and a saturating streak counter.
// Ports:
//   clk    : system clock
//   resetn : asynchronous reset, ACTIVE HIGH despite its name (1 = reset)
//   bus    : hit_scorer_if.slave (score_enable, note_strobe, led_pattern,
//            keys_n in; score digits, streak, hit_pulse, miss_pulse out)
// A clean key edge shows up on hit_pulse/miss_pulse DEBOUNCE_CYCLES+3 clock
// edges later (2 sync flops, DEBOUNCE_CYCLES counting edges, 1 judging edge).
module hit_scorer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic        clk,
    input  logic        resetn,
    hit_scorer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] pressed;
    logic [3:0] stable_keys;
    logic [3:0] rise;
    logic       press_evt_q;

    state_t     state_q;
    logic [3:0] note_q;
    logic       hit_q;
    logic       miss_q;
    logic       hit_d;
    logic       miss_d;
    logic [3:0] tens_q;
    logic [3:0] ones_q;
    logic [6:0] streak_q;

    // Two-flop synchroniser; idles at "released" (keys are active-low).
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            sync1_q <= 4'b1111;
            sync2_q <= 4'b1111;
        end else begin
            sync1_q <= bus.keys_n;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = ~sync2_q;

    // Per-key debounce: a change is accepted only after it has been seen
    // for DEBOUNCE_CYCLES consecutive cycles.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_key
            logic [CNT_W-1:0] cnt_q;
            logic             stable_q;

            always_ff @(posedge clk or posedge resetn) begin
                if (resetn) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else if (pressed[gi] != stable_q) begin
                    if (cnt_q == CNT_LAST) begin
                        stable_q <= pressed[gi];
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_q <= '0;
                end
            end

            assign stable_keys[gi] = stable_q;
            // This key's stable state is about to go released -> pressed.
            assign rise[gi] = pressed[gi] & ~stable_q & (cnt_q == CNT_LAST);
        end
    endgenerate

    // Registered alongside the stable bits so press_evt_q and stable_keys
    // describe the same chord in the judging cycle.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            press_evt_q <= 1'b0;
        end else begin
            press_evt_q <= |rise;
        end
    end

    // Judging decision for the current note. A strobe closes the old note
    // even if a press lands in the same cycle; the press counts only if it
    // completes the chord exactly.
    always_comb begin
        hit_d  = 1'b0;
        miss_d = 1'b0;
        if (bus.score_enable && state_q == ARMED) begin
            if (bus.note_strobe) begin
                if (press_evt_q && stable_keys == note_q) begin
                    hit_d = 1'b1;
                end else begin
                    miss_d = 1'b1;
                end
            end else if (press_evt_q) begin
                if (stable_keys == note_q) begin
                    hit_d = 1'b1;
                end else if ((stable_keys & ~note_q) != 4'b0000) begin
                    miss_d = 1'b1;
                end
                // Otherwise a proper subset: the chord is still being built.
            end
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q  <= IDLE;
            note_q   <= 4'b0000;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            streak_q <= 7'd0;
        end else begin
            hit_q  <= hit_d;
            miss_q <= miss_d;

            if (!bus.score_enable) begin
                state_q <= IDLE;
            end else if (bus.note_strobe) begin
                // Every state latches a new note; an empty pattern has
                // nothing to judge.
                note_q  <= bus.led_pattern;
                state_q <= (bus.led_pattern == 4'b0000) ? DONE : ARMED;
            end else if (hit_d || miss_d) begin
                state_q <= DONE;
            end

            if (hit_d) begin
                if (!(tens_q == 4'd9 && ones_q == 4'd9)) begin
                    if (ones_q == 4'd9) begin
                        ones_q <= 4'd0;
                        tens_q <= tens_q + 4'd1;
                    end else begin
                        ones_q <= ones_q + 4'd1;
                    end
                end
                if (streak_q != 7'd127) begin
                    streak_q <= streak_q + 7'd1;
                end
            end else if (miss_d) begin
                streak_q <= 7'd0;
            end
        end
    end

    assign bus.score_10s_digit = tens_q;
    assign bus.score_1s_digit  = ones_q;
    assign bus.streak          = streak_q;
    assign bus.hit_pulse       = hit_q;
    assign bus.miss_pulse      = miss_q;
endmodule
